// File: rtl/seg7_scan_display.sv
// seg7_scan_display: scans 2*NUM_FIELDS digits (seg, one-hot digit_en, colon, frame_start) from a per-frame snapshot of current_time or stopwatch_time chosen by state
module seg7_scan_display #(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W = 6,
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_DIV = 500000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic [2:0] state,
  input  logic [NUM_FIELDS*FIELD_W-1:0] current_time,
  input  logic [NUM_FIELDS*FIELD_W-1:0] stopwatch_time,
  output logic [6:0] seg,
  output logic [2*NUM_FIELDS-1:0] digit_en,
  output logic colon,
  output logic frame_start
);
  localparam int DIGITS = 2*NUM_FIELDS;
  localparam int IW = $clog2(DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int VW = NUM_FIELDS*FIELD_W;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] digit_idx, next_idx;
  logic [BW-1:0] blink_cnt;
  logic blink_phase, scan_tick, wrap, blink_tick, over, blank, colon_n;
  logic [VW-1:0] snap, src, frame_val;
  logic [2:0] st_q, frame_st;
  logic [FIELD_W-1:0] fv;
  logic [3:0] dig;
  logic [6:0] seg_n;
  int fld, set_f;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'b0111111;
      4'd1: decode = 7'b0000110;
      4'd2: decode = 7'b1011011;
      4'd3: decode = 7'b1001111;
      4'd4: decode = 7'b1100110;
      4'd5: decode = 7'b1101101;
      4'd6: decode = 7'b1111101;
      4'd7: decode = 7'b0000111;
      4'd8: decode = 7'b1111111;
      4'd9: decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction
  always_comb begin
    scan_tick = scan_cnt == SW'(SCAN_DIV-1);
    wrap = scan_tick && digit_idx == IW'(DIGITS-1);
    next_idx = digit_idx == IW'(DIGITS-1) ? '0 : digit_idx + IW'(1);
    blink_tick = blink_cnt == BW'(BLINK_DIV-1);
    src = (state == 3'd4 || state == 3'd5) ? stopwatch_time : current_time;
    frame_val = wrap ? src : snap;
    frame_st = wrap ? state : st_q;
    fld = int'(next_idx) >> 1;
    set_f = frame_st == 3'd1 ? NUM_FIELDS-1 : frame_st == 3'd2 ? 1 : 0;
    fv = frame_val[fld*FIELD_W +: FIELD_W];
    over = 32'(fv) > 32'd99;
    dig = 4'(next_idx[0] ? 32'(fv) / 32'd10 : 32'(fv) % 32'd10);
    blank = frame_st[2:1] == 2'b11 || (frame_st inside {3'd1, 3'd2, 3'd3} && fld == set_f && blink_phase);
    seg_n = blank ? 7'b0000000 : over ? 7'b1000000 : decode(dig);
    colon_n = (state == 3'd0 || state == 3'd4) ? ~blink_phase : state[2:1] != 2'b11;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      digit_idx <= IW'(DIGITS-1);
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      snap <= '0;
      st_q <= '0;
      seg <= {7{SEG_ACTIVE_LOW}};
      digit_en <= {DIGITS{SEG_ACTIVE_LOW}};
      colon <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SW'(1);
      blink_cnt <= blink_tick ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_phase ^ blink_tick;
      colon <= colon_n;
      frame_start <= wrap;
      if (wrap) begin
        snap <= src;
        st_q <= state;
      end
      if (scan_tick) begin
        digit_idx <= next_idx;
        seg <= seg_n ^ {7{SEG_ACTIVE_LOW}};
        digit_en <= (DIGITS'(1) << next_idx) ^ {DIGITS{SEG_ACTIVE_LOW}};
      end
    end
  end
endmodule
